// File: rtl/serv_decode_fifo.sv
// serv_decode_fifo: instruction FIFO that predecodes class flags at write time.
module serv_decode_fifo #(
  parameter int DEPTH = 2,
  parameter bit MDU   = 1'b0
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic [29:0]                  i_wb_rdt,
  input  logic                         i_wb_en,
  input  logic                         i_next,
  output logic                         o_full,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [4:0]                   o_opcode,
  output logic [2:0]                   o_funct3,
  output logic                         o_imm30,
  output logic [3:0]                   o_csr_bits,
  output logic                         o_mem_op,
  output logic                         o_branch_op,
  output logic                         o_rd_op,
  output logic                         o_mdu_op,
  output logic                         o_illegal
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic       imm30;
    logic [3:0] csr_bits;
    logic       mem_op;
    logic       branch_op;
    logic       rd_op;
    logic       mdu_op;
    logic       illegal;
  } entry_t;
  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      op;
  logic            legal_op, push, pop;
  logic            unused;
  assign unused = &{1'b0, i_wb_rdt[22:21], i_wb_rdt[17:13], i_wb_rdt[9:5]};
  // i_wb_rdt[k] holds instruction bit k+2
  always_comb begin
    op                 = i_wb_rdt[4:0];
    legal_op           = op inside {5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                                    5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
    wr_entry.opcode    = op;
    wr_entry.funct3    = i_wb_rdt[12:10];
    wr_entry.imm30     = i_wb_rdt[28];
    wr_entry.csr_bits  = {i_wb_rdt[24], i_wb_rdt[20:18]};
    wr_entry.mem_op    = (op == 5'b00000) || (op == 5'b01000);
    wr_entry.branch_op = op[4] & ~op[2];
    wr_entry.rd_op     = op inside {5'b00000, 5'b00100, 5'b00101, 5'b01100,
                                    5'b01101, 5'b11001, 5'b11011, 5'b11100};
    wr_entry.mdu_op    = MDU && (op == 5'b01100) && (i_wb_rdt[29:23] == 7'b0000001);
    wr_entry.illegal   = !legal_op || (!MDU && (op == 5'b01100) && i_wb_rdt[23]);
  end
  assign o_full  = count_q == CW'(DEPTH);
  assign o_valid = count_q != '0;
  assign pop     = i_next & o_valid;
  assign push    = i_wb_en & (~o_full | pop);
  always_comb begin
    rd_ptr_d = i_flush ? '0 : pop  ? ((DEPTH == 1) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
    wr_ptr_d = i_flush ? '0 : push ? ((DEPTH == 1) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
    count_d  = i_flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !i_flush) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end
  assign head        = mem_q[rd_ptr_q];
  assign o_count     = count_q;
  assign o_opcode    = head.opcode;
  assign o_funct3    = head.funct3;
  assign o_imm30     = head.imm30;
  assign o_csr_bits  = head.csr_bits;
  assign o_mem_op    = head.mem_op;
  assign o_branch_op = head.branch_op;
  assign o_rd_op     = head.rd_op;
  assign o_mdu_op    = head.mdu_op;
  assign o_illegal   = head.illegal;
endmodule

// File: tb/tb_serv_decode_fifo.sv
// tb_serv_decode_fifo: directed checks on a DEPTH=2/MDU=0 and a DEPTH=4/MDU=1 instance sharing stimulus.
module tb_serv_decode_fifo;
  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic [29:0] i_wb_rdt = '0;
  logic        i_wb_en = 1'b0;
  logic        i_next = 1'b0;
  logic        a_full, a_valid, a_imm30, a_mem, a_br, a_rd, a_mdu, a_ill;
  logic [1:0]  a_count;
  logic [4:0]  a_opcode;
  logic [2:0]  a_funct3;
  logic [3:0]  a_csr;
  logic        b_full, b_valid, b_imm30, b_mem, b_br, b_rd, b_mdu, b_ill;
  logic [2:0]  b_count;
  logic [4:0]  b_opcode;
  logic [2:0]  b_funct3;
  logic [3:0]  b_csr;
  int          n_cmp = 0;
  int          n_err = 0;
  localparam logic [31:0] ADDI = 32'h00A30313;
  localparam logic [31:0] LW   = 32'h00052283;
  localparam logic [31:0] SW   = 32'h00552023;
  localparam logic [31:0] BEQ  = 32'h00000063;
  localparam logic [31:0] JAL  = 32'h0000006F;
  localparam logic [31:0] MUL  = 32'h023100B3;
  localparam logic [31:0] SUB  = 32'h403100B3;
  localparam logic [31:0] BAD  = 32'h0000007F;

  always #5 clk = ~clk;

  serv_decode_fifo #(.DEPTH(2), .MDU(1'b0)) u2 (
    .clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
    .o_full(a_full), .o_valid(a_valid), .i_next(i_next), .o_count(a_count), .o_opcode(a_opcode),
    .o_funct3(a_funct3), .o_imm30(a_imm30), .o_csr_bits(a_csr), .o_mem_op(a_mem),
    .o_branch_op(a_br), .o_rd_op(a_rd), .o_mdu_op(a_mdu), .o_illegal(a_ill));

  serv_decode_fifo #(.DEPTH(4), .MDU(1'b1)) u4 (
    .clk(clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
    .o_full(b_full), .o_valid(b_valid), .i_next(i_next), .o_count(b_count), .o_opcode(b_opcode),
    .o_funct3(b_funct3), .o_imm30(b_imm30), .o_csr_bits(b_csr), .o_mem_op(b_mem),
    .o_branch_op(b_br), .o_rd_op(b_rd), .o_mdu_op(b_mdu), .o_illegal(b_ill));

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    i_wb_en = 1'b0;
    i_next  = 1'b0;
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if ({a_valid, a_full, a_count} !== 4'b0) begin n_err++; $display("FAIL reset_a got v/f/c=%b%b%0d exp 000", a_valid, a_full, a_count); end
    n_cmp++; if ({b_valid, b_full, b_count} !== 5'b0) begin n_err++; $display("FAIL reset_b got v/f/c=%b%b%0d exp 000", b_valid, b_full, b_count); end
    n_cmp++; if ({a_opcode, a_funct3, a_imm30, a_csr, a_mem, a_br, a_rd, a_mdu, a_ill} !== 18'b0) begin n_err++; $display("FAIL reset_head got %b%b exp 0", a_opcode, a_ill); end
    cycle();
    cycle();
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_addi();
    i_wb_rdt = ADDI[31:2];
    i_wb_en  = 1'b1;
    cycle();
    i_wb_en  = 1'b0;
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b exp 1", a_valid); end
    n_cmp++; if (a_opcode !== 5'b00100 || a_funct3 !== 3'b000) begin n_err++; $display("FAIL addi_fields got %b/%b exp 00100/000", a_opcode, a_funct3); end
    n_cmp++; if (a_rd !== 1'b1 || a_ill !== 1'b0) begin n_err++; $display("FAIL addi_flags got rd=%b ill=%b exp 1/0", a_rd, a_ill); end
    n_cmp++; if (a_count !== 2'd1) begin n_err++; $display("FAIL addi_count got %0d exp 1", a_count); end
    i_next = 1'b1;
    cycle();
    i_next = 1'b0;
    n_cmp++; if (a_valid !== 1'b0 || a_count !== 2'd0) begin n_err++; $display("FAIL addi_pop got v=%b c=%0d exp 0/0", a_valid, a_count); end
  endtask

  task automatic test_full_drop();
    i_wb_en = 1'b1;
    i_wb_rdt = LW[31:2];  cycle();
    i_wb_rdt = SW[31:2];  cycle();
    i_wb_rdt = BEQ[31:2]; cycle();
    i_wb_en = 1'b0;
    n_cmp++; if (a_full !== 1'b1 || a_count !== 2'd2) begin n_err++; $display("FAIL full_state got f=%b c=%0d exp 1/2", a_full, a_count); end
    n_cmp++; if (b_count !== 3'd3 || b_full !== 1'b0) begin n_err++; $display("FAIL full_b_count got c=%0d f=%b exp 3/0", b_count, b_full); end
    n_cmp++; if (a_mem !== 1'b1 || a_rd !== 1'b1 || a_funct3 !== 3'b010) begin n_err++; $display("FAIL head_lw got mem=%b rd=%b f3=%b exp 1/1/010", a_mem, a_rd, a_funct3); end
    i_next = 1'b1;
    cycle();
    n_cmp++; if (a_mem !== 1'b1 || a_rd !== 1'b0 || a_opcode !== 5'b01000) begin n_err++; $display("FAIL head_sw got mem=%b rd=%b op=%b exp 1/0/01000", a_mem, a_rd, a_opcode); end
    cycle();
    i_next = 1'b0;
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL drained_a got v=%b exp 0", a_valid); end
    n_cmp++; if (b_count !== 3'd1 || b_br !== 1'b1 || b_rd !== 1'b0) begin n_err++; $display("FAIL head_beq got c=%0d br=%b rd=%b exp 1/1/0", b_count, b_br, b_rd); end
    i_next = 1'b1;
    cycle();
    cycle();
    i_next = 1'b0;
    n_cmp++; if (b_valid !== 1'b0 || b_count !== 3'd0) begin n_err++; $display("FAIL empty_pop_b got v=%b c=%0d exp 0/0", b_valid, b_count); end
  endtask

  task automatic test_empty_push_pop();
    i_wb_rdt = JAL[31:2];
    i_wb_en = 1'b1;
    i_next  = 1'b1;
    cycle();
    i_wb_en = 1'b0;
    i_next  = 1'b0;
    n_cmp++; if (a_count !== 2'd1 || b_count !== 3'd1) begin n_err++; $display("FAIL empty_pushpop got %0d/%0d exp 1/1", a_count, b_count); end
    n_cmp++; if (a_opcode !== 5'b11011 || a_br !== 1'b1 || a_rd !== 1'b1) begin n_err++; $display("FAIL head_jal got op=%b br=%b rd=%b exp 11011/1/1", a_opcode, a_br, a_rd); end
    flush();
  endtask

  task automatic test_decode();
    i_wb_en = 1'b1;
    i_wb_rdt = MUL[31:2]; cycle();
    i_wb_rdt = SUB[31:2]; cycle();
    i_wb_en = 1'b0;
    n_cmp++; if (a_mdu !== 1'b0 || a_ill !== 1'b1) begin n_err++; $display("FAIL mul_mdu0 got mdu=%b ill=%b exp 0/1", a_mdu, a_ill); end
    n_cmp++; if (b_mdu !== 1'b1 || b_ill !== 1'b0) begin n_err++; $display("FAIL mul_mdu1 got mdu=%b ill=%b exp 1/0", b_mdu, b_ill); end
    i_next = 1'b1;
    cycle();
    i_next = 1'b0;
    n_cmp++; if (a_imm30 !== 1'b1 || a_csr !== 4'b0011 || a_ill !== 1'b0 || a_mdu !== 1'b0) begin n_err++; $display("FAIL sub_fields got imm30=%b csr=%b ill=%b mdu=%b exp 1/0011/0/0", a_imm30, a_csr, a_ill, a_mdu); end
    flush();
    i_wb_rdt = BAD[31:2];
    i_wb_en = 1'b1;
    cycle();
    i_wb_en = 1'b0;
    n_cmp++; if (a_ill !== 1'b1 || b_ill !== 1'b1 || a_mem !== 1'b0) begin n_err++; $display("FAIL bad_op got ill=%b/%b mem=%b exp 1/1/0", a_ill, b_ill, a_mem); end
    flush();
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [4:0] op;
    logic [2:0] f3;
    logic [31:0] ins;
    bit en, nx, pp, ps;
    for (int i = 0; i < 19; i++) begin
      en = (i < 15);
      nx = (i >= 4);
      op = 5'(i * 3);
      f3 = 3'(i);
      ins = {17'b0, f3, 5'b0, op, 2'b11};
      if (q.size() > 0) begin
        n_cmp++; if ({b_opcode, b_funct3} !== q[0]) begin n_err++; $display("FAIL wrap_head[%0d] got %h exp %h", i, {b_opcode, b_funct3}, q[0]); end
      end
      i_wb_rdt = ins[31:2];
      i_wb_en = en;
      i_next  = nx;
      cycle();
      pp = nx && q.size() > 0;
      ps = en && (q.size() < 4 || pp);
      if (pp) void'(q.pop_front());
      if (ps) q.push_back({op, f3});
      n_cmp++; if (b_count !== 3'(q.size())) begin n_err++; $display("FAIL wrap_count[%0d] got %0d exp %0d", i, b_count, q.size()); end
    end
    i_wb_en = 1'b0;
    i_next  = 1'b0;
    n_cmp++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty got v=%b exp 0", b_valid); end
    flush();
  endtask

  task automatic test_flush();
    i_wb_en = 1'b1;
    i_wb_rdt = LW[31:2];   cycle();
    i_wb_rdt = SW[31:2];   cycle();
    i_wb_rdt = ADDI[31:2]; cycle();
    n_cmp++; if (b_count !== 3'd3) begin n_err++; $display("FAIL pre_flush got %0d exp 3", b_count); end
    i_wb_rdt = BEQ[31:2];
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    i_wb_en = 1'b0;
    n_cmp++; if (b_count !== 3'd0 || b_valid !== 1'b0 || a_count !== 2'd0) begin n_err++; $display("FAIL flush_clear got %0d/%b/%0d exp 0/0/0", b_count, b_valid, a_count); end
    i_wb_rdt = JAL[31:2];
    i_wb_en = 1'b1;
    cycle();
    i_wb_en = 1'b0;
    n_cmp++; if (b_opcode !== 5'b11011 || b_count !== 3'd1) begin n_err++; $display("FAIL post_flush got op=%b c=%0d exp 11011/1", b_opcode, b_count); end
    flush();
  endtask

  task automatic test_async_reset();
    i_wb_en = 1'b1;
    i_wb_rdt = LW[31:2]; cycle();
    i_wb_rdt = SW[31:2]; cycle();
    i_wb_en = 1'b0;
    n_cmp++; if (a_count !== 2'd2) begin n_err++; $display("FAIL pre_reset got %0d exp 2", a_count); end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (a_valid !== 1'b0 || a_count !== 2'd0 || b_count !== 3'd0) begin n_err++; $display("FAIL async_reset got %b/%0d/%0d exp 0/0/0", a_valid, a_count, b_count); end
    n_cmp++; if (a_opcode !== 5'b0 || a_mem !== 1'b0) begin n_err++; $display("FAIL async_head got op=%b mem=%b exp 0/0", a_opcode, a_mem); end
    @(negedge clk);
    i_rst_n = 1'b1;
    i_wb_rdt = ADDI[31:2];
    i_wb_en = 1'b1;
    cycle();
    i_wb_en = 1'b0;
    n_cmp++; if (a_valid !== 1'b1 || a_count !== 2'd1 || a_opcode !== 5'b00100) begin n_err++; $display("FAIL after_reset got %b/%0d/%b exp 1/1/00100", a_valid, a_count, a_opcode); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_full_drop();
    test_empty_push_pop();
    test_decode();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
